// File: rtl/accelerator_pkg.sv
// accelerator_pkg
// Shared types and widths for the core-side APU request/response path.
//   apu_dispatch_state_t : dispatcher FSM states (IDLE, REQ, WAIT_RESP)
//   APU_OP_W / APU_FLAGS_W / APU_NUM_OPERANDS / APU_OPERAND_W : field widths
//   apu_instr_t          : one buffered vector instruction (operands, op, flags)
package accelerator_pkg;

   localparam int APU_OP_W         = 6;
   localparam int APU_FLAGS_W      = 15;
   localparam int APU_NUM_OPERANDS = 3;
   localparam int APU_OPERAND_W    = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_RESP = 2'd2
   } apu_dispatch_state_t;

   typedef struct packed {
      logic [APU_NUM_OPERANDS-1:0][APU_OPERAND_W-1:0] operands;
      logic [APU_OP_W-1:0]                            op;
      logic [APU_FLAGS_W-1:0]                         flags;
   } apu_instr_t;

endpackage

// File: rtl/apu_dispatcher_if.sv
// apu_dispatcher_if
// Bundles the decode-stage handover and the accelerator request/response
// signals of the APU dispatcher.
//   instr_valid/instr_ready + instr_operands/instr_op/instr_flags : upstream push
//   apu_req + apu_operands/apu_op/apu_flags_o                     : request to accelerator
//   apu_gnt, apu_rvalid                                           : accelerator handshake
// Modports:
//   master : the dispatcher (drives instr_ready and the request side)
//   slave  : the environment (decode stage + accelerator)
interface apu_dispatcher_if;
   import accelerator_pkg::*;

   logic                                           instr_valid;
   logic                                           instr_ready;
   logic [APU_NUM_OPERANDS-1:0][APU_OPERAND_W-1:0] instr_operands;
   logic [APU_OP_W-1:0]                            instr_op;
   logic [APU_FLAGS_W-1:0]                         instr_flags;

   logic                                           apu_req;
   logic [APU_NUM_OPERANDS-1:0][APU_OPERAND_W-1:0] apu_operands;
   logic [APU_OP_W-1:0]                            apu_op;
   logic [APU_FLAGS_W-1:0]                         apu_flags_o;
   logic                                           apu_gnt;
   logic                                           apu_rvalid;

   modport master (
      input  instr_valid, instr_operands, instr_op, instr_flags, apu_gnt, apu_rvalid,
      output instr_ready, apu_req, apu_operands, apu_op, apu_flags_o
   );

   modport slave (
      output instr_valid, instr_operands, instr_op, instr_flags, apu_gnt, apu_rvalid,
      input  instr_ready, apu_req, apu_operands, apu_op, apu_flags_o
   );

endinterface

// File: rtl/apu_instr_fifo.sv
// apu_instr_fifo
// Small synchronous FIFO of apu_instr_t entries, DEPTH a power of two >= 2.
//   clk, n_reset (async, active low)
//   push, wr_data : write at the tail; ignored while full (even in a pop cycle)
//   pop, rd_data  : rd_data always shows the head; pop ignored while empty
//   full, empty, count : derived from the registered occupancy
module apu_instr_fifo
   import accelerator_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             push,
   input  apu_instr_t       wr_data,
   input  logic             pop,
   output apu_instr_t       rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   apu_instr_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) wide, so incrementing past the last
   // entry wraps to zero on its own.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: entries are only read once count says they
   // were written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/apu_dispatcher.sv
// apu_dispatcher
// Core-side initiator for the APU interface. Buffers instructions from decode
// in apu_instr_fifo and issues them one at a time: apu_req is held with a
// stable payload until apu_gnt, then apu_rvalid is awaited before the next
// issue, so at most one instruction is outstanding.
//   clk, n_reset (async, active low)
//   bus         : apu_dispatcher_if.master (upstream push + accelerator handshake)
//   done        : one-cycle pulse, combinational with apu_rvalid in WAIT_RESP
//   busy        : FIFO non-empty or FSM not idle
//   fifo_count  : FIFO occupancy
//   timeout_err : sticky response-watchdog error
// Optional feature: define APU_TIMEOUT_EN to build the response watchdog
// (TIMEOUT_CYCLES cycles in WAIT_RESP). Without it timeout_err is tied low.
module apu_dispatcher
   import accelerator_pkg::*;
#(
   parameter  int DEPTH          = 4,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int CNT_W          = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 n_reset,
   apu_dispatcher_if.master     bus,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 timeout_err
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("apu_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
   end

   apu_dispatch_state_t state_q, state_d;
   apu_instr_t          payload_q, payload_d;
   apu_instr_t          incoming;
   apu_instr_t          head;
   logic                req_q, req_d;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic                timeout_hit;

   assign incoming = {bus.instr_operands, bus.instr_op, bus.instr_flags};

   apu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (bus.instr_valid),
      .wr_data (incoming),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Next-state and output-register logic. When idle with an empty FIFO, an
   // instruction being pushed this cycle is loaded straight from the input so
   // the request goes out the cycle after the push; the FIFO still stores it
   // and it is popped at grant like any other entry.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      payload_d = payload_q;
      fifo_pop  = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               payload_d = head;
               req_d     = 1'b1;
               state_d   = REQ;
            end else if (bus.instr_valid) begin
               payload_d = incoming;
               req_d     = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (bus.apu_gnt) begin
               fifo_pop = 1'b1;
               req_d    = 1'b0;
               state_d  = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (bus.apu_rvalid) begin
               done = 1'b1;
               if (!fifo_empty) begin
                  payload_d = head;
                  req_d     = 1'b1;
                  state_d   = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state plus the registered request and payload seen by the accelerator.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         payload_q <= payload_d;
      end
   end

   assign bus.apu_req      = req_q;
   assign bus.apu_operands = payload_q.operands;
   assign bus.apu_op       = payload_q.op;
   assign bus.apu_flags_o  = payload_q.flags;
   assign bus.instr_ready  = !fifo_full;
   assign busy             = !fifo_empty || (state_q != IDLE);

`ifdef APU_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;

   // wd_cnt holds zero outside WAIT_RESP, so every entry starts a fresh count;
   // it reads TIMEOUT_CYCLES-1 in the last cycle a response may still arrive.
   assign timeout_hit = (state_q == WAIT_RESP) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counter and the sticky error flag.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q != WAIT_RESP || timeout_hit) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (timeout_hit && !bus.apu_rvalid) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_apu_dispatcher.sv
// tb_apu_dispatcher
// Self-checking bench for apu_dispatcher (DEPTH=4, TIMEOUT_CYCLES=8).
// Expected behaviour comes from an issue timeline computed from the protocol
// rules: an instruction pushed into an idle, empty block is requested the next
// cycle; a request lasts until its grant cycle; the response arrives some
// cycles later and the next queued instruction is requested the cycle after.
// Watchdog scenarios are compiled in when APU_TIMEOUT_EN is defined.
module tb_apu_dispatcher;
   import accelerator_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic             clk;
   logic             n_reset;
   logic             done;
   logic             busy;
   logic [CNT_W-1:0] fifo_count;
   logic             timeout_err;

   int               checks;
   int               errors;
   apu_instr_t       exp_payload;
   apu_instr_t       obs_payload;

   apu_dispatcher_if bus ();

   apu_dispatcher #(
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .bus         (bus),
      .done        (done),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .timeout_err (timeout_err)
   );

   assign obs_payload = {bus.apu_operands, bus.apu_op, bus.apu_flags_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic apu_instr_t rand_instr();
      apu_instr_t t;
      t.operands[0] = $urandom;
      t.operands[1] = $urandom;
      t.operands[2] = $urandom;
      t.op          = APU_OP_W'($urandom);
      t.flags       = APU_FLAGS_W'($urandom);
      return t;
   endfunction

   task automatic drive_idle();
      bus.instr_valid = 1'b0;
      {bus.instr_operands, bus.instr_op, bus.instr_flags} = '0;
      bus.apu_gnt     = 1'b0;
      bus.apu_rvalid  = 1'b0;
   endtask

   task automatic drive_instr(input logic valid, input apu_instr_t t);
      bus.instr_valid = valid;
      {bus.instr_operands, bus.instr_op, bus.instr_flags} = t;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      n_reset = 1'b1;
      @(negedge clk);
      checks++; if (bus.apu_req !== 1'b0) begin errors++; $display("FAIL reset_req actual=%0b expected=0", bus.apu_req); end
      checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%0b expected=1", bus.instr_ready); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count actual=%0d expected=0", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%0b expected=0", done); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout actual=%0b expected=0", timeout_err); end
      checks++; if (obs_payload !== '0) begin errors++; $display("FAIL reset_payload actual=%h expected=0", obs_payload); end
      exp_payload = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      apu_instr_t ins;
      ins = '0;
      ins.operands[0] = 32'h0000_0057;
      ins.op          = 6'h15;
      for (int c = 0; c <= 4; c++) begin
         drive_instr(c == 0, ins);
         bus.apu_gnt    = (c == 1);
         bus.apu_rvalid = (c == 3);
         @(negedge clk);
         checks++; if (bus.apu_req !== (c == 1)) begin errors++; $display("FAIL single_req cycle=%0d actual=%0b expected=%0b", c, bus.apu_req, (c == 1)); end
         checks++; if (done !== (c == 3)) begin errors++; $display("FAIL single_done cycle=%0d actual=%0b expected=%0b", c, done, (c == 3)); end
         checks++; if (busy !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL single_busy cycle=%0d actual=%0b expected=%0b", c, busy, (c >= 1 && c <= 3)); end
         if (c >= 1) begin
            checks++; if (obs_payload !== ins) begin errors++; $display("FAIL single_payload cycle=%0d actual=%h expected=%h", c, obs_payload, ins); end
         end
         @(posedge clk);
         #1;
      end
      drive_idle();
      exp_payload = ins;
   endtask

   // n instructions pushed on consecutive cycles from cycle 0. Instruction i
   // is requested from s[i] to its grant cycle gc[i] and answered at rv[i];
   // the next one is requested from rv[i]+1. With noise set, gnt and rvalid
   // toggle randomly whenever the block should be ignoring them.
   task automatic test_stream(input string tag, input int n, input int g_fix, input int r_fix, input bit noise);
      apu_instr_t ins [DEPTH];
      int         s   [DEPTH];
      int         gc  [DEPTH];
      int         rv  [DEPTH];
      int         last_c;
      for (int i = 0; i < n; i++) begin
         int g;
         int r;
         ins[i] = rand_instr();
         g      = noise ? int'($urandom_range(0, 3)) : g_fix;
         r      = noise ? int'($urandom_range(0, 4)) : r_fix;
         s[i]   = (i == 0) ? 1 : rv[i-1] + 1;
         gc[i]  = s[i] + g;
         rv[i]  = gc[i] + 1 + r;
      end
      last_c = rv[n-1] + 2;
      for (int c = 0; c <= last_c; c++) begin
         logic       in_req, in_wait, gnt_d, rv_d, req_exp, done_exp, busy_exp, ready_exp;
         int         cnt_exp;
         apu_instr_t pay_exp;
         in_req = 1'b0; in_wait = 1'b0; gnt_d = 1'b0; rv_d = 1'b0;
         req_exp = 1'b0; done_exp = 1'b0; busy_exp = 1'b0;
         cnt_exp = (c < n) ? c : n;
         pay_exp = exp_payload;
         for (int i = 0; i < n; i++) begin
            if (c >= s[i] && c <= gc[i]) begin in_req = 1'b1; req_exp = 1'b1; gnt_d = (c == gc[i]); end
            if (c > gc[i] && c <= rv[i]) begin in_wait = 1'b1; rv_d = (c == rv[i]); done_exp = (c == rv[i]); end
            if (c >= s[i] && c <= rv[i]) busy_exp = 1'b1;
            if (gc[i] < c) cnt_exp--;
            if (s[i] <= c) pay_exp = ins[i];
         end
         if (noise && !in_req) gnt_d = 1'($urandom_range(0, 1));
         if (noise && !in_wait) rv_d = 1'($urandom_range(0, 1));
         if (cnt_exp > 0) busy_exp = 1'b1;
         ready_exp = (cnt_exp < DEPTH);
         drive_instr(c < n, (c < n) ? ins[c] : rand_instr());
         bus.apu_gnt    = gnt_d;
         bus.apu_rvalid = rv_d;
         @(negedge clk);
         checks++; if (bus.apu_req !== req_exp) begin errors++; $display("FAIL %s_req cycle=%0d actual=%0b expected=%0b", tag, c, bus.apu_req, req_exp); end
         checks++; if (obs_payload !== pay_exp) begin errors++; $display("FAIL %s_payload cycle=%0d actual=%h expected=%h", tag, c, obs_payload, pay_exp); end
         checks++; if (done !== done_exp) begin errors++; $display("FAIL %s_done cycle=%0d actual=%0b expected=%0b", tag, c, done, done_exp); end
         checks++; if (busy !== busy_exp) begin errors++; $display("FAIL %s_busy cycle=%0d actual=%0b expected=%0b", tag, c, busy, busy_exp); end
         checks++; if (fifo_count !== CNT_W'(cnt_exp)) begin errors++; $display("FAIL %s_count cycle=%0d actual=%0d expected=%0d", tag, c, fifo_count, cnt_exp); end
         checks++; if (bus.instr_ready !== ready_exp) begin errors++; $display("FAIL %s_ready cycle=%0d actual=%0b expected=%0b", tag, c, bus.instr_ready, ready_exp); end
         checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL %s_timeout cycle=%0d actual=%0b expected=0", tag, c, timeout_err); end
         @(posedge clk);
         #1;
      end
      drive_idle();
      exp_payload = ins[n-1];
   endtask

   task automatic test_gnt_delay();
      test_stream("gnt_delay", 1, 3, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      test_stream("b2b", 3, 0, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 20; k++) begin
         test_stream("random", int'($urandom_range(1, DEPTH)), 0, 0, 1'b1);
      end
   endtask

   // Five pushes with the grant withheld: four fill the FIFO, the fifth
   // waits until the first grant frees a slot. gnt/rvalid are then held high
   // so the queue drains at one issue every two cycles.
   task automatic test_full();
      apu_instr_t ins [5];
      apu_instr_t got [$];
      int         dones;
      dones = 0;
      for (int k = 0; k < 5; k++) ins[k] = rand_instr();
      for (int c = 0; c <= 18; c++) begin
         drive_instr(c <= 7, ins[(c < 4) ? c : 4]);
         bus.apu_gnt    = (c >= 6 && c <= 16);
         bus.apu_rvalid = (c >= 7 && c <= 16);
         @(negedge clk);
         if (bus.apu_req && bus.apu_gnt) got.push_back(obs_payload);
         if (done) dones++;
         if (c >= 1 && c <= 6) begin
            checks++; if (bus.apu_req !== 1'b1 || obs_payload !== ins[0]) begin errors++; $display("FAIL full_hold cycle=%0d actual=%0b/%h expected=1/%h", c, bus.apu_req, obs_payload, ins[0]); end
         end
         if (c == 4 || c == 6 || c == 8) begin
            checks++; if (fifo_count !== 3'd4 || bus.instr_ready !== 1'b0) begin errors++; $display("FAIL full_stall cycle=%0d actual=%0d/%0b expected=4/0", c, fifo_count, bus.instr_ready); end
         end
         if (c == 7) begin
            checks++; if (fifo_count !== 3'd3 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL full_after_grant cycle=%0d actual=%0d/%0b expected=3/1", c, fifo_count, bus.instr_ready); end
         end
         @(posedge clk);
         #1;
      end
      drive_idle();
      checks++; if (got.size() !== 5) begin errors++; $display("FAIL full_issue_count actual=%0d expected=5", got.size()); end
      for (int k = 0; k < 5; k++) begin
         if (k < got.size()) begin
            checks++; if (got[k] !== ins[k]) begin errors++; $display("FAIL full_order index=%0d actual=%h expected=%h", k, got[k], ins[k]); end
         end
      end
      checks++; if (dones !== 5) begin errors++; $display("FAIL full_done_count actual=%0d expected=5", dones); end
      exp_payload = ins[4];
   endtask

   // Three pushes, first one granted at cycle 1; in cycle 3 the block sits in
   // WAIT_RESP with two entries queued when reset is pulsed.
   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         drive_instr(1'b1, rand_instr());
         bus.apu_gnt = (c == 1);
         @(posedge clk);
         #1;
      end
      drive_idle();
      @(negedge clk);
      checks++; if (fifo_count !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre actual=%0d/%0b expected=2/1", fifo_count, busy); end
      #2;
      n_reset        = 1'b0;
      bus.apu_rvalid = 1'b1;
      #1;
      checks++; if (bus.apu_req !== 1'b0) begin errors++; $display("FAIL rstmid_req actual=%0b expected=0", bus.apu_req); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done actual=%0b expected=0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy actual=%0b expected=0", busy); end
      checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rstmid_count actual=%0d expected=0", fifo_count); end
      checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready actual=%0b expected=1", bus.instr_ready); end
      checks++; if (obs_payload !== '0) begin errors++; $display("FAIL rstmid_payload actual=%h expected=0", obs_payload); end
      @(posedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++; if (done !== 1'b0 || bus.apu_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after cycle=%0d actual=%0b%0b%0b expected=000", c, done, bus.apu_req, busy); end
      end
      drive_idle();
      exp_payload = '0;
      @(posedge clk);
      #1;
   endtask

`ifdef APU_TIMEOUT_EN
   // Two pushes; the first is granted at cycle 1 and never answered, so the
   // watchdog fires after WAIT_RESP cycles 2..9 and the second is requested
   // at cycle 11 and answered at cycle 12.
   task automatic test_timeout();
      apu_instr_t ins [2];
      ins[0] = rand_instr();
      ins[1] = rand_instr();
      for (int c = 0; c <= 13; c++) begin
         apu_instr_t pay_exp;
         pay_exp = (c >= 11) ? ins[1] : ((c >= 1) ? ins[0] : exp_payload);
         drive_instr(c <= 1, ins[(c == 0) ? 0 : 1]);
         bus.apu_gnt    = (c == 1 || c == 11);
         bus.apu_rvalid = (c == 12);
         @(negedge clk);
         checks++; if (timeout_err !== (c >= 10)) begin errors++; $display("FAIL timeout_err cycle=%0d actual=%0b expected=%0b", c, timeout_err, (c >= 10)); end
         checks++; if (done !== (c == 12)) begin errors++; $display("FAIL timeout_done cycle=%0d actual=%0b expected=%0b", c, done, (c == 12)); end
         checks++; if (bus.apu_req !== (c == 1 || c == 11)) begin errors++; $display("FAIL timeout_req cycle=%0d actual=%0b expected=%0b", c, bus.apu_req, (c == 1 || c == 11)); end
         checks++; if (obs_payload !== pay_exp) begin errors++; $display("FAIL timeout_payload cycle=%0d actual=%h expected=%h", c, obs_payload, pay_exp); end
         checks++; if (busy !== (c >= 1 && c <= 12)) begin errors++; $display("FAIL timeout_busy cycle=%0d actual=%0b expected=%0b", c, busy, (c >= 1 && c <= 12)); end
         @(posedge clk);
         #1;
      end
      drive_idle();
      exp_payload = ins[1];
   endtask

   task automatic test_timeout_reset();
      n_reset = 1'b0;
      #1;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_reset_during actual=%0b expected=0", timeout_err); end
      @(negedge clk);
      n_reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_reset_after actual=%0b expected=0", timeout_err); end
      exp_payload = '0;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      n_reset = 1'b0;
      drive_idle();
      test_reset();
      test_single();
      test_gnt_delay();
      test_back_to_back();
      test_full();
      test_random();
      test_reset_mid();
`ifdef APU_TIMEOUT_EN
      test_timeout();
      test_timeout_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
